// File: rtl/gen_fifo_defines_pkg.sv
// Shared definitions for the function-generator address path: widths, FSM state type
// and small helpers used by the address generator and its phase accumulator.
package gen_fifo_defines_pkg;

    localparam int GEN_DATA_WIDTH   = 16;
    localparam int GEN_LUT_ADDR     = 8;
    localparam int GEN_PHASE_WIDTH  = 24;
    localparam int GEN_PERIOD_WIDTH = 16;

    typedef enum logic [1:0] {
        GEN_IDLE  = 2'd0,
        GEN_RUN   = 2'd1,
        GEN_DRAIN = 2'd2
    } gen_state_t;

    // Period counter increment that sticks at all-ones in continuous mode.
    function automatic logic [GEN_PERIOD_WIDTH-1:0] sat_inc16(input logic [GEN_PERIOD_WIDTH-1:0] value);
        logic [GEN_PERIOD_WIDTH-1:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/funct_generator_phase_acc.sv
// Phase accumulator: clears on a new start, adds the tuning word on each accepted
// sample and exposes the next sum plus its carry so the caller can flag a wrap.
module funct_generator_phase_acc
    import gen_fifo_defines_pkg::*;
#(
    parameter int PHASE_WIDTH = GEN_PHASE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   advance,
    input  logic [PHASE_WIDTH-1:0] ftw,
    output logic [PHASE_WIDTH-1:0] acc,
    output logic [PHASE_WIDTH-1:0] sum,
    output logic                   carry
);

    logic [PHASE_WIDTH-1:0] acc_r;
    logic [PHASE_WIDTH:0]   ext_sum_s;

    assign ext_sum_s = {1'b0, acc_r} + {1'b0, ftw};
    assign sum       = ext_sum_s[PHASE_WIDTH-1:0];
    assign carry     = ext_sum_s[PHASE_WIDTH];
    assign acc       = acc_r;

    // Accumulator register: clear has priority, otherwise advance only on an accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
        end else if (clear) begin
            acc_r <= '0;
        end else if (advance) begin
            acc_r <= ext_sum_s[PHASE_WIDTH-1:0];
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/funct_generator_addr_gen.sv
// DDS-style address generator feeding funct_generator_lut: a phase accumulator whose
// top bits plus an offset form the LUT read address, with a ready/valid handshake.
module funct_generator_addr_gen
    import gen_fifo_defines_pkg::*;
#(
    parameter int DATA_WIDTH  = GEN_DATA_WIDTH,
    parameter int ADDR_WIDTH  = GEN_LUT_ADDR,
    parameter int PHASE_WIDTH = GEN_PHASE_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic                        stop_i,
    input  logic [PHASE_WIDTH-1:0]      ftw_i,
    input  logic [ADDR_WIDTH-1:0]       phase_off_i,
    input  logic [GEN_PERIOD_WIDTH-1:0] num_periods_i,
    input  logic                        ready_i,
    output logic [ADDR_WIDTH-1:0]       read_addr_o,
    output logic                        addr_valid_o,
    output logic                        data_valid_o,
    output logic                        wrap_o,
    output logic                        busy_o
);

    generate
        if (PHASE_WIDTH < ADDR_WIDTH || DATA_WIDTH < 1) begin : g_param_check
            $error("funct_generator_addr_gen: PHASE_WIDTH must be >= ADDR_WIDTH and DATA_WIDTH >= 1");
        end
    endgenerate

    gen_state_t                  state_r;
    gen_state_t                  state_s;
    logic [PHASE_WIDTH-1:0]      ftw_r;
    logic [ADDR_WIDTH-1:0]       off_r;
    logic [GEN_PERIOD_WIDTH-1:0] num_r;
    logic [GEN_PERIOD_WIDTH-1:0] cnt_r;
    logic [GEN_PERIOD_WIDTH-1:0] cnt_next_s;
    logic [ADDR_WIDTH-1:0]       addr_r;
    logic                        valid_r;
    logic                        data_valid_r;
    logic                        wrap_r;

    logic [PHASE_WIDTH-1:0]      acc_s;
    logic [PHASE_WIDTH-1:0]      sum_s;
    logic                        carry_s;
    logic                        load_s;
    logic                        accept_s;
    logic                        wrap_s;
    logic                        period_done_s;
    logic                        acc_zero_s;

    assign load_s        = (state_r == GEN_IDLE) && start_i;
    assign accept_s      = valid_r && ready_i;
    assign wrap_s        = accept_s && carry_s;
    assign cnt_next_s    = sat_inc16(cnt_r);
    assign period_done_s = wrap_s && (num_r != 16'd0) && (cnt_next_s == num_r);
    assign acc_zero_s    = (acc_s == '0);

    funct_generator_phase_acc #(
        .PHASE_WIDTH (PHASE_WIDTH)
    ) u_phase_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (load_s),
        .advance (accept_s),
        .ftw     (ftw_r),
        .acc     (acc_s),
        .sum     (sum_s),
        .carry   (carry_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= GEN_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; the wrap closing the last requested period ends the run outright,
    // since there is no partial period left to drain.
    always_comb begin
        state_s = state_r;
        case (state_r)
            GEN_IDLE: begin
                if (start_i) begin
                    state_s = GEN_RUN;
                end else begin
                    state_s = GEN_IDLE;
                end
            end
            GEN_RUN: begin
                if (period_done_s) begin
                    state_s = GEN_IDLE;
                end else if (stop_i) begin
                    if (acc_zero_s || wrap_s) begin
                        state_s = GEN_IDLE;
                    end else begin
                        state_s = GEN_DRAIN;
                    end
                end else begin
                    state_s = GEN_RUN;
                end
            end
            GEN_DRAIN: begin
                if (wrap_s || (stop_i && acc_zero_s)) begin
                    state_s = GEN_IDLE;
                end else begin
                    state_s = GEN_DRAIN;
                end
            end
            default: begin
                state_s = GEN_IDLE;
            end
        endcase
    end

    // Datapath: captured settings, period counter and the registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ftw_r        <= '0;
            off_r        <= '0;
            num_r        <= 16'd0;
            cnt_r        <= 16'd0;
            addr_r       <= '0;
            valid_r      <= 1'b0;
            data_valid_r <= 1'b0;
            wrap_r       <= 1'b0;
        end else begin
            wrap_r       <= wrap_s;
            data_valid_r <= accept_s;
            valid_r      <= (state_s != GEN_IDLE);
            if (load_s) begin
                ftw_r  <= ftw_i;
                off_r  <= phase_off_i;
                num_r  <= num_periods_i;
                cnt_r  <= 16'd0;
                addr_r <= phase_off_i;
            end else begin
                if (accept_s) begin
                    addr_r <= sum_s[PHASE_WIDTH-1 -: ADDR_WIDTH] + off_r;
                end else begin
                    addr_r <= addr_r;
                end
                if (wrap_s) begin
                    cnt_r <= cnt_next_s;
                end else begin
                    cnt_r <= cnt_r;
                end
            end
        end
    end

    assign read_addr_o  = addr_r;
    assign addr_valid_o = valid_r;
    assign data_valid_o = data_valid_r;
    assign wrap_o       = wrap_r;
    assign busy_o       = (state_r != GEN_IDLE);

endmodule

// File: tb/tb_funct_generator_addr_gen.sv
// Directed bench for funct_generator_addr_gen at PHASE_WIDTH=16, ADDR_WIDTH=8;
// outputs are sampled on the falling edge, inputs change on the falling edge.
module tb_funct_generator_addr_gen;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        stop_i;
    logic [15:0] ftw_i;
    logic [7:0]  phase_off_i;
    logic [15:0] num_periods_i;
    logic        ready_i;
    logic [7:0]  read_addr_o;
    logic        addr_valid_o;
    logic        data_valid_o;
    logic        wrap_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    funct_generator_addr_gen #(
        .DATA_WIDTH  (16),
        .ADDR_WIDTH  (8),
        .PHASE_WIDTH (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .ftw_i         (ftw_i),
        .phase_off_i   (phase_off_i),
        .num_periods_i (num_periods_i),
        .ready_i       (ready_i),
        .read_addr_o   (read_addr_o),
        .addr_valid_o  (addr_valid_o),
        .data_valid_o  (data_valid_o),
        .wrap_o        (wrap_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one clock; returns on the falling edge where the first address is visible.
    task automatic pulse_start(input logic [15:0] ftw, input logic [7:0] off, input logic [15:0] num);
        @(negedge clk);
        start_i       = 1'b1;
        ftw_i         = ftw;
        phase_off_i   = off;
        num_periods_i = num;
        @(negedge clk);
        start_i       = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy_o !== 1'b0 && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({read_addr_o, addr_valid_o, data_valid_o, wrap_o, busy_o} !== 12'h000) begin
            bad++;
            $display("FAIL reset_state: got addr=%h av=%b dv=%b wrap=%b busy=%b, want all 0",
                     read_addr_o, addr_valid_o, data_valid_o, wrap_o, busy_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy_o !== 1'b0 || addr_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_idle: busy=%b av=%b, want 0 0", busy_o, addr_valid_o);
        end
    endtask

    task automatic test_single_period();
        logic [7:0] exp_addr;
        int wraps;
        wraps = 0;
        exp_addr = 8'h00;
        pulse_start(16'h0100, 8'h00, 16'd1);
        for (int i = 0; i < 256; i++) begin
            total++;
            if (addr_valid_o !== 1'b1 || read_addr_o !== exp_addr) begin
                bad++;
                $display("FAIL single_addr[%0d]: got av=%b addr=%h, want 1 %h", i, addr_valid_o, read_addr_o, exp_addr);
            end
            if (i > 0) begin
                total++;
                if (data_valid_o !== 1'b1) begin
                    bad++;
                    $display("FAIL single_dv[%0d]: got %b, want 1", i, data_valid_o);
                end
            end
            if (wrap_o === 1'b1) wraps++;
            exp_addr = exp_addr + 8'h01;
            @(negedge clk);
        end
        if (wrap_o === 1'b1) wraps++;
        total++;
        if (wraps != 1) begin
            bad++;
            $display("FAIL single_wrap_count: got %0d, want 1", wraps);
        end
        total++;
        if (busy_o !== 1'b0 || addr_valid_o !== 1'b0 || wrap_o !== 1'b1) begin
            bad++;
            $display("FAIL single_end: got busy=%b av=%b wrap=%b, want 0 0 1", busy_o, addr_valid_o, wrap_o);
        end
        @(negedge clk);
        total++;
        if (wrap_o !== 1'b0 || data_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL single_quiet: got wrap=%b dv=%b, want 0 0", wrap_o, data_valid_o);
        end
    endtask

    task automatic test_offset_wrap();
        logic [7:0] exp_addr;
        exp_addr = 8'hFE;
        pulse_start(16'h0400, 8'hFE, 16'd1);
        for (int i = 0; i < 64; i++) begin
            total++;
            if (read_addr_o !== exp_addr || addr_valid_o !== 1'b1) begin
                bad++;
                $display("FAIL offset_addr[%0d]: got av=%b addr=%h, want 1 %h", i, addr_valid_o, read_addr_o, exp_addr);
            end
            exp_addr = exp_addr + 8'h04;
            @(negedge clk);
        end
        total++;
        if (busy_o !== 1'b0 || wrap_o !== 1'b1) begin
            bad++;
            $display("FAIL offset_end: got busy=%b wrap=%b, want 0 1", busy_o, wrap_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_seq [4];
        int wraps;
        int n;
        exp_seq[0] = 8'h00; exp_seq[1] = 8'h80; exp_seq[2] = 8'h00; exp_seq[3] = 8'h80;
        wraps = 0;
        pulse_start(16'h8000, 8'h00, 16'd2);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (read_addr_o !== exp_seq[i] || addr_valid_o !== 1'b1) begin
                bad++;
                $display("FAIL b2b_addr[%0d]: got av=%b addr=%h, want 1 %h", i, addr_valid_o, read_addr_o, exp_seq[i]);
            end
            if (wrap_o === 1'b1) wraps++;
            @(negedge clk);
        end
        if (wrap_o === 1'b1) wraps++;
        total++;
        if (wraps != 2 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_periods: got wraps=%0d busy=%b, want 2 0", wraps, busy_o);
        end
        wait_idle(n);
    endtask

    task automatic test_stall();
        int n;
        pulse_start(16'h0100, 8'h00, 16'd0);
        repeat (3) @(negedge clk);
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (read_addr_o !== 8'h03 || addr_valid_o !== 1'b1 || data_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got addr=%h av=%b dv=%b, want 03 1 0", i, read_addr_o, addr_valid_o, data_valid_o);
            end
        end
        ready_i = 1'b1;
        @(negedge clk);
        total++;
        if (read_addr_o !== 8'h04 || data_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL stall_resume: got addr=%h dv=%b, want 04 1", read_addr_o, data_valid_o);
        end
        pulse_stop();
        wait_idle(n);
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL stall_drain_timeout: busy=%b after %0d cycles, want 0", busy_o, n);
        end
    endtask

    task automatic test_stop_drain();
        logic [7:0] last_addr;
        int n;
        last_addr = 8'h00;
        pulse_start(16'h0100, 8'h00, 16'd0);
        repeat (64) @(negedge clk);
        total++;
        if (read_addr_o !== 8'h40) begin
            bad++;
            $display("FAIL drain_pre_stop: got addr=%h, want 40", read_addr_o);
        end
        pulse_stop();
        n = 0;
        while (addr_valid_o === 1'b1 && n < 400) begin
            last_addr = read_addr_o;
            @(negedge clk);
            n++;
        end
        total++;
        if (last_addr !== 8'hFF || busy_o !== 1'b0 || wrap_o !== 1'b1) begin
            bad++;
            $display("FAIL drain_last: got last=%h busy=%b wrap=%b, want FF 0 1", last_addr, busy_o, wrap_o);
        end
    endtask

    task automatic test_ftw_zero();
        pulse_start(16'h0000, 8'h33, 16'd0);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (read_addr_o !== 8'h33 || addr_valid_o !== 1'b1) begin
                bad++;
                $display("FAIL ftw0_const[%0d]: got addr=%h av=%b, want 33 1", i, read_addr_o, addr_valid_o);
            end
            @(negedge clk);
        end
        pulse_stop();
        total++;
        if (busy_o !== 1'b0 || addr_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL ftw0_stop: got busy=%b av=%b, want 0 0", busy_o, addr_valid_o);
        end
    endtask

    task automatic test_ignore_rules();
        int n;
        @(negedge clk);
        pulse_stop();
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL stop_in_idle: got busy=%b, want 0", busy_o);
        end
        start_i = 1'b1; stop_i = 1'b1;
        ftw_i = 16'h0100; phase_off_i = 8'h10; num_periods_i = 16'd0;
        @(negedge clk);
        start_i = 1'b0; stop_i = 1'b0;
        total++;
        if (busy_o !== 1'b1 || read_addr_o !== 8'h10) begin
            bad++;
            $display("FAIL start_stop_same: got busy=%b addr=%h, want 1 10", busy_o, read_addr_o);
        end
        start_i = 1'b1; ftw_i = 16'h0001; phase_off_i = 8'h00;
        @(negedge clk);
        start_i = 1'b0;
        total++;
        if (read_addr_o !== 8'h11) begin
            bad++;
            $display("FAIL start_in_run: got addr=%h, want 11", read_addr_o);
        end
        pulse_stop();
        wait_idle(n);
    endtask

    task automatic test_reset_mid_run();
        pulse_start(16'h0100, 8'h05, 16'd0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({read_addr_o, addr_valid_o, data_valid_o, wrap_o, busy_o} !== 12'h000) begin
            bad++;
            $display("FAIL reset_abort: got addr=%h av=%b dv=%b wrap=%b busy=%b, want all 0",
                     read_addr_o, addr_valid_o, data_valid_o, wrap_o, busy_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (data_valid_o !== 1'b0 || addr_valid_o !== 1'b0 || busy_o !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_quiet[%0d]: got dv=%b av=%b busy=%b, want 0 0 0", i, data_valid_o, addr_valid_o, busy_o);
            end
        end
        pulse_start(16'h0100, 8'h00, 16'd0);
        total++;
        if (read_addr_o !== 8'h00 || addr_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL restart_after_reset: got addr=%h av=%b, want 00 1", read_addr_o, addr_valid_o);
        end
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; ready_i = 1'b1;
        ftw_i = 16'h0000; phase_off_i = 8'h00; num_periods_i = 16'd0;
        test_reset();
        test_single_period();
        test_offset_wrap();
        test_back_to_back();
        test_stall();
        test_stop_drain();
        test_ftw_zero();
        test_ignore_rules();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
